// File: rtl/tx_gearbox_feed.sv
// Feeds a sync-header gearbox: 2-entry FIFO, per-slot sequence counter with pause slot, idle insertion on underflow.
// Optional TX_GEARBOX_FEED_UNDERFLOW_CNT_EN adds a saturating count of inserted idle blocks.
module tx_gearbox_feed #(
    parameter int DATA_W = 64,
    parameter int HEAD_W = 2,
    parameter int SEQ_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [HEAD_W-1:0] in_head_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              gb_full_i,
    output logic [SEQ_W-1:0]  seq_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              align_err_o
`ifdef TX_GEARBOX_FEED_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_cnt_o
`endif
);

    localparam int                 SHIFT_N   = DATA_W / HEAD_W;
    localparam logic [SEQ_W-1:0]   SHIFT_SEQ = SEQ_W'(SHIFT_N);
    localparam logic [HEAD_W-1:0]  IDLE_HEAD = HEAD_W'(2);
    localparam logic [DATA_W-1:0]  IDLE_DATA = DATA_W'(8'h1E);

    logic [HEAD_W-1:0] fh_q [2];
    logic [HEAD_W-1:0] fh_d [2];
    logic [DATA_W-1:0] fd_q [2];
    logic [DATA_W-1:0] fd_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [HEAD_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              align_err_q, align_err_d;

    logic              fifo_full;
    logic              pause;
    logic              push;
    logic              pop;
    logic              idle;

`ifdef TX_GEARBOX_FEED_UNDERFLOW_CNT_EN
    logic [15:0]       uf_cnt_q, uf_cnt_d;
`endif

    // Readiness depends only on registered occupancy, never on this cycle's pop.
    assign fifo_full  = (cnt_q == 2'd2);
    assign in_ready_o = !fifo_full;

    always_comb begin
        seq_d       = (seq_q == SHIFT_SEQ) ? '0 : seq_q + SEQ_W'(1);
        pause       = (seq_d == SHIFT_SEQ);
        push        = in_valid_i && !fifo_full;
        pop         = !pause && (cnt_q != 2'd0);
        idle        = !pause && (cnt_q == 2'd0);

        fh_d        = fh_q;
        fd_d        = fd_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + 2'(push) - 2'(pop);

        head_d      = head_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        align_err_d = align_err_q | (gb_full_i != (seq_q == SHIFT_SEQ));

        if (push) begin
            fh_d[wr_ptr_q] = in_head_i;
            fd_d[wr_ptr_q] = in_data_i;
            wr_ptr_d       = !wr_ptr_q;
        end

        if (pop) begin
            head_d   = fh_q[rd_ptr_q];
            data_d   = fd_q[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = !rd_ptr_q;
        end else if (idle) begin
            head_d   = IDLE_HEAD;
            data_d   = IDLE_DATA;
            valid_d  = 1'b1;
        end
    end

`ifdef TX_GEARBOX_FEED_UNDERFLOW_CNT_EN
    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (idle && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign underflow_cnt_o = uf_cnt_q;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fh_q        <= '{default: '0};
            fd_q        <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            seq_q       <= '0;
            head_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            fh_q        <= fh_d;
            fd_q        <= fd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            head_q      <= head_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            align_err_q <= align_err_d;
        end
    end

    assign seq_o       = seq_q;
    assign head_o      = head_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign align_err_o = align_err_q;

endmodule

// File: tb/tb_tx_gearbox_feed.sv
// Scoreboard bench for tx_gearbox_feed: queue-based reference model predicts each output slot.
module tb_tx_gearbox_feed;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [1:0]  in_head_i = '0;
    logic [63:0] in_data_i = '0;
    logic        gb_full_i = 1'b0;
    logic [5:0]  seq_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        valid_o;
    logic        align_err_o;
`ifdef TX_GEARBOX_FEED_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_o;
`endif

    tx_gearbox_feed dut (
        .clk         (clk),
        .nreset      (nreset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_head_i   (in_head_i),
        .in_data_i   (in_data_i),
        .gb_full_i   (gb_full_i),
        .seq_o       (seq_o),
        .head_o      (head_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .align_err_o (align_err_o)
`ifdef TX_GEARBOX_FEED_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt_o (underflow_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  seq;
        logic        v;
        logic [1:0]  h;
        logic [63:0] d;
        logic        e;
        logic [15:0] uf;
    } exp_t;

    exp_t        eq[$];
    logic [65:0] mq[$];
    int          m_seq;
    logic [1:0]  m_h;
    logic [63:0] m_d;
    logic        m_err;
    logic [15:0] m_uf;
    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] payload = 64'd0;

    task automatic model_reset();
        mq.delete();
        m_seq = 0;
        m_h   = '0;
        m_d   = '0;
        m_err = 1'b0;
        m_uf  = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // One stimulus slot: drive at the falling edge, predict the slot produced by the next rising edge.
    task automatic cycle(input bit v, input logic [1:0] h, input logic [63:0] d, input bit inj);
        exp_t e;
        bit   rdy;
        bit   gbf;
        int   nxt;
        @(negedge clk);
        nreset = 1'b1;
        rdy = (mq.size() < 2);
        chk("in_ready", 64'(in_ready_o), 64'(rdy));
        gbf = inj ? 1'b1 : (m_seq == 32);
        in_valid_i = v;
        in_head_i  = h;
        in_data_i  = d;
        gb_full_i  = gbf;
        if (gbf != (m_seq == 32)) m_err = 1'b1;
        nxt = (m_seq == 32) ? 0 : m_seq + 1;
        if (nxt == 32) begin
            e.v = 1'b0;
        end else if (mq.size() > 0) begin
            {m_h, m_d} = mq.pop_front();
            e.v = 1'b1;
        end else begin
            m_h = 2'b10;
            m_d = 64'h1E;
            e.v = 1'b1;
            if (m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
        end
        if (v && rdy) mq.push_back({h, d});
        e.seq = 6'(nxt);
        e.h   = m_h;
        e.d   = m_d;
        e.e   = m_err;
        e.uf  = m_uf;
        eq.push_back(e);
        m_seq = nxt;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 2'b00, 64'd0, 1'b0);
    endtask

    task automatic count_cycle();
        cycle(1'b1, 2'b01, payload, 1'b0);
        if (mq.size() > 0 && mq[mq.size()-1][63:0] == payload) payload = payload + 64'd1;
    endtask

    // Asserts reset between edges; it is released by the next cycle() call.
    task automatic do_reset();
        @(negedge clk);
        nreset     = 1'b0;
        in_valid_i = 1'b0;
        gb_full_i  = 1'b0;
        #1;
        chk("rst_seq", 64'(seq_o), 64'd0);
        chk("rst_head", 64'(head_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_err", 64'(align_err_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
`ifdef TX_GEARBOX_FEED_UNDERFLOW_CNT_EN
        chk("rst_uf", 64'(underflow_cnt_o), 64'd0);
`endif
        model_reset();
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                n_total++;
                if (seq_o === e.seq && valid_o === e.v && head_o === e.h &&
                    data_o === e.d && align_err_o === e.e
`ifdef TX_GEARBOX_FEED_UNDERFLOW_CNT_EN
                    && underflow_cnt_o === e.uf
`endif
                   ) begin
                    n_pass++;
                end else begin
                    $display("FAIL slot: got seq=%0d v=%b h=%b d=%h err=%b want seq=%0d v=%b h=%b d=%h err=%b",
                             seq_o, valid_o, head_o, data_o, align_err_o, e.seq, e.v, e.h, e.d, e.e);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        repeat (40) idle_cycle();

        repeat (80) count_cycle();

        for (int i = 0; i < 200; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b0);
        end

        guard = 0;
        while ((mq.size() > 0 || m_seq != 30) && guard < 80) begin
            idle_cycle();
            guard++;
        end
        chk("align_wait", 64'(m_seq), 64'd30);
        cycle(1'b1, 2'b01, 64'hDEADBEEF_CAFEF00D, 1'b0);
        repeat (4) idle_cycle();

        guard = 0;
        while (m_seq != 5 && guard < 40) begin
            idle_cycle();
            guard++;
        end
        chk("seq5_wait", 64'(m_seq), 64'd5);
        cycle(1'b0, 2'b00, 64'd0, 1'b1);
        repeat (40) count_cycle();

        guard = 0;
        while (mq.size() < 2 && guard < 60) begin
            count_cycle();
            guard++;
        end
        chk("fill_wait", 64'(mq.size()), 64'd2);
        do_reset();
        repeat (40) idle_cycle();

        for (int i = 0; i < 100; i++) begin
            cycle($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b0);
        end

        guard = 0;
        while (eq.size() > 0 && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 64'(eq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
